// File: rtl/rename_pkg.sv
// rename_pkg: shared widths and the rename-to-issue packet
package rename_pkg;
    localparam int ARCH_REGS  = 32;
    localparam int PHYS_REGS  = 64;
    localparam int ARCH_W     = 5;
    localparam int PHYS_W     = 6;
    localparam int ROB_W      = 6;
    localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int PTR_W      = $clog2(FREE_DEPTH);
    localparam int CNT_W      = $clog2(FREE_DEPTH + 1);

    typedef struct packed {
        logic [PHYS_W-1:0] rd;
        logic [PHYS_W-1:0] rs1;
        logic [PHYS_W-1:0] rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [6:0]        opcode;
        logic [31:0]       immediate;
        logic [ROB_W-1:0]  rob_index;
    } issue_pkt_t;
endpackage

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical registers, preloaded with 32..63
module free_list
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [PHYS_W-1:0] push_phys,
    input  logic              pop,
    output logic [PHYS_W-1:0] pop_phys,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);
    logic [PHYS_W-1:0] slots [FREE_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic              push_ok, pop_ok;

    // a push into a full list is dropped, so tail never overruns head
    assign push_ok  = push && count != CNT_W'(FREE_DEPTH);
    assign pop_ok   = pop && !empty;
    assign pop_phys = slots[head];
    assign empty    = count == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FREE_DEPTH);
            for (int i = 0; i < FREE_DEPTH; i++) slots[i] <= PHYS_W'(ARCH_REGS + i);
        end else begin
            if (push_ok) begin
                slots[tail] <= push_phys;
                tail        <= tail + 1'b1;
            end
            if (pop_ok) head <= head + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end
endmodule

// File: rtl/rename_stage.sv
// rename_stage: RAT lookup, destination allocation and registered packet to the issue queue
module rename_stage
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [ARCH_W-1:0] dec_rd,
    input  logic [ARCH_W-1:0] dec_rs1,
    input  logic [ARCH_W-1:0] dec_rs2,
    input  logic              dec_writes_rd,
    input  logic [2:0]        dec_funct3,
    input  logic [6:0]        dec_funct7,
    input  logic [6:0]        dec_opcode,
    input  logic [31:0]       dec_immediate,
    input  logic [ROB_W-1:0]  rob_tail_index,
    input  logic              rob_full,
    input  logic              issue_queue_full,
    input  logic              commit_free_enable,
    input  logic [PHYS_W-1:0] commit_free_phys,
    output logic              write_enable,
    output logic [PHYS_W-1:0] phys_rd,
    output logic [PHYS_W-1:0] phys_rs1,
    output logic [PHYS_W-1:0] phys_rs2,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [6:0]        opcode,
    output logic [31:0]       immediate,
    output logic [ROB_W-1:0]  ROB_entry_index,
    output logic [PHYS_W-1:0] old_phys_rd,
    output logic              free_list_empty
);
    logic [PHYS_W-1:0] rat [ARCH_REGS];
    logic [PHYS_W-1:0] alloc_phys;
    logic [CNT_W-1:0]  free_count;
    logic              accept, alloc;
    issue_pkt_t        pkt;

    free_list u_free_list (
        .clk      (clk),
        .reset    (reset),
        .push     (commit_free_enable && commit_free_phys != '0),
        .push_phys(commit_free_phys),
        .pop      (alloc),
        .pop_phys (alloc_phys),
        .count    (free_count),
        .empty    (free_list_empty)
    );

    assign dec_ready = !issue_queue_full && !rob_full && free_count != '0;
    assign accept    = dec_valid && dec_ready;
    assign alloc     = accept && dec_writes_rd && dec_rd != '0;

    // sources read the RAT before this cycle's rd update lands
    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable <= 1'b0;
            pkt          <= '0;
            old_phys_rd  <= '0;
            for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PHYS_W'(i);
        end else begin
            write_enable <= accept;
            if (accept) begin
                pkt.rd        <= alloc ? alloc_phys : '0;
                pkt.rs1       <= rat[dec_rs1];
                pkt.rs2       <= rat[dec_rs2];
                pkt.funct3    <= dec_funct3;
                pkt.funct7    <= dec_funct7;
                pkt.opcode    <= dec_opcode;
                pkt.immediate <= dec_immediate;
                pkt.rob_index <= rob_tail_index;
                old_phys_rd   <= alloc ? rat[dec_rd] : '0;
            end
            if (alloc) rat[dec_rd] <= alloc_phys;
        end
    end

    assign phys_rd         = pkt.rd;
    assign phys_rs1        = pkt.rs1;
    assign phys_rs2        = pkt.rs2;
    assign funct3          = pkt.funct3;
    assign funct7          = pkt.funct7;
    assign opcode          = pkt.opcode;
    assign immediate       = pkt.immediate;
    assign ROB_entry_index = pkt.rob_index;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed and random checks against a queue-based rename model
module tb_rename_stage;
    logic        clk = 0;
    logic        reset = 1;
    logic        dec_valid = 0, dec_ready, dec_writes_rd = 0;
    logic [4:0]  dec_rd = 0, dec_rs1 = 0, dec_rs2 = 0;
    logic [2:0]  dec_funct3 = 0;
    logic [6:0]  dec_funct7 = 0, dec_opcode = 0;
    logic [31:0] dec_immediate = 0;
    logic [5:0]  rob_tail_index = 0;
    logic        rob_full = 0, issue_queue_full = 0, commit_free_enable = 0;
    logic [5:0]  commit_free_phys = 0;
    logic        write_enable, free_list_empty;
    logic [5:0]  phys_rd, phys_rs1, phys_rs2, ROB_entry_index, old_phys_rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7, opcode;
    logic [31:0] immediate;

    rename_stage dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_writes_rd(dec_writes_rd),
        .dec_funct3(dec_funct3), .dec_funct7(dec_funct7), .dec_opcode(dec_opcode),
        .dec_immediate(dec_immediate), .rob_tail_index(rob_tail_index), .rob_full(rob_full),
        .issue_queue_full(issue_queue_full), .commit_free_enable(commit_free_enable),
        .commit_free_phys(commit_free_phys), .write_enable(write_enable), .phys_rd(phys_rd),
        .phys_rs1(phys_rs1), .phys_rs2(phys_rs2), .funct3(funct3), .funct7(funct7),
        .opcode(opcode), .immediate(immediate), .ROB_entry_index(ROB_entry_index),
        .old_phys_rd(old_phys_rd), .free_list_empty(free_list_empty)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int rat_m [32];
    int fl [$];
    logic [31:0] e_we, e_rd, e_rs1, e_rs2, e_f3, e_f7, e_op, e_imm, e_rob, e_old;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pkt();
        chk("write_enable", 32'(write_enable), e_we);
        chk("phys_rd", 32'(phys_rd), e_rd);
        chk("phys_rs1", 32'(phys_rs1), e_rs1);
        chk("phys_rs2", 32'(phys_rs2), e_rs2);
        chk("funct3", 32'(funct3), e_f3);
        chk("funct7", 32'(funct7), e_f7);
        chk("opcode", 32'(opcode), e_op);
        chk("immediate", immediate, e_imm);
        chk("rob_index", 32'(ROB_entry_index), e_rob);
        chk("old_phys_rd", 32'(old_phys_rd), e_old);
        chk("free_list_empty", 32'(free_list_empty), 32'(fl.size() == 0));
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        dec_valid = 0; commit_free_enable = 0; issue_queue_full = 0; rob_full = 0;
        for (int i = 0; i < 32; i++) rat_m[i] = i;
        fl.delete();
        for (int k = 0; k < 32; k++) fl.push_back(32 + k);
        {e_we, e_rd, e_rs1, e_rs2, e_f3, e_f7, e_op, e_imm, e_rob, e_old} = '0;
        chk_pkt();
        chk("reset_ready", 32'(dec_ready), 1);
    endtask

    task automatic cyc(input bit v, input bit w, input int rd, input int rs1, input int rs2,
                       input int rob = 0, input bit iqf = 0, input bit robf = 0,
                       input bit fe = 0, input int fp = 0);
        bit ready_m, acc, alloc, push_ok;
        dec_valid = v; dec_writes_rd = w;
        dec_rd = 5'(rd); dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
        rob_tail_index = 6'(rob); issue_queue_full = iqf; rob_full = robf;
        commit_free_enable = fe; commit_free_phys = 6'(fp);
        dec_funct3 = 3'($urandom); dec_funct7 = 7'($urandom);
        dec_opcode = 7'($urandom); dec_immediate = $urandom;
        #1;
        ready_m = !iqf && !robf && fl.size() != 0;
        chk("dec_ready", 32'(dec_ready), 32'(ready_m));
        acc = v && ready_m;
        alloc = acc && w && rd != 0;
        push_ok = fe && fp != 0 && fl.size() < 32;
        e_we = 32'(acc);
        if (acc) begin
            e_rs1 = rat_m[rs1]; e_rs2 = rat_m[rs2];
            e_rd  = alloc ? fl[0] : 0;
            e_old = alloc ? rat_m[rd] : 0;
            e_f3 = dec_funct3; e_f7 = dec_funct7; e_op = dec_opcode;
            e_imm = dec_immediate; e_rob = rob;
        end
        if (alloc) rat_m[rd] = fl.pop_front();
        if (push_ok) fl.push_back(fp);
        @(posedge clk); #1;
        chk_pkt();
    endtask

    initial begin
        // add x1,x2,x3 then x4 = x1 + x1
        do_reset();
        cyc(1, 1, 1, 2, 3, 20);
        chk("t1_we", 32'(write_enable), 1);
        chk("t1_rd", 32'(phys_rd), 32);
        chk("t1_rs1", 32'(phys_rs1), 2);
        chk("t1_rs2", 32'(phys_rs2), 3);
        chk("t1_old", 32'(old_phys_rd), 1);
        chk("t1_rob", 32'(ROB_entry_index), 20);
        cyc(1, 1, 4, 1, 1, 21);
        chk("t2_rs1", 32'(phys_rs1), 32);
        chk("t2_rs2", 32'(phys_rs2), 32);
        chk("t2_rd", 32'(phys_rd), 33);
        chk("t2_old", 32'(old_phys_rd), 4);
        cyc(0, 1, 7, 7, 7);
        chk("idle_we", 32'(write_enable), 0);
        chk("idle_hold_rd", 32'(phys_rd), 33);
        // add x5,x5,x5
        do_reset();
        cyc(1, 1, 5, 5, 5);
        chk("t3_rs1", 32'(phys_rs1), 5);
        chk("t3_rd", 32'(phys_rd), 32);
        chk("t3_old", 32'(old_phys_rd), 5);
        cyc(1, 1, 6, 5, 0);
        chk("t3_next_rs1", 32'(phys_rs1), 32);
        // rd = x0 does not allocate
        do_reset();
        cyc(1, 1, 0, 1, 2);
        chk("t4_rd", 32'(phys_rd), 0);
        chk("t4_old", 32'(old_phys_rd), 0);
        cyc(1, 1, 3, 0, 0);
        chk("t4_next_rd", 32'(phys_rd), 32);
        chk("t4_x0", 32'(phys_rs1), 0);
        // push into a full list and push of physical 0 are dropped
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 40);
        cyc(1, 1, 9, 0, 0);
        chk("full_push_rd", 32'(phys_rd), 32);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 10, 9, 0);
        chk("zero_push_rd", 32'(phys_rd), 33);
        chk("zero_push_rs1", 32'(phys_rs1), 32);
        // exhaustion and recovery
        do_reset();
        for (int i = 0; i < 32; i++) cyc(1, 1, (i % 31) + 1, 0, 0);
        chk("exh_empty", 32'(free_list_empty), 1);
        chk("exh_ready", 32'(dec_ready), 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("exh_we", 32'(write_enable), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("exh_ready_after", 32'(dec_ready), 1);
        cyc(1, 1, 2, 0, 0);
        chk("exh_rd7", 32'(phys_rd), 7);
        // backpressure
        do_reset();
        cyc(1, 1, 1, 0, 0, 0, 1);
        chk("iqf_we", 32'(write_enable), 0);
        cyc(1, 1, 2, 0, 0, 0, 0, 1);
        chk("robf_we", 32'(write_enable), 0);
        cyc(1, 0, 0, 1, 2);
        chk("iqf_rat_rs1", 32'(phys_rs1), 1);
        chk("iqf_rat_rs2", 32'(phys_rs2), 2);
        // count == 1 with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 31; i++) cyc(1, 1, (i % 31) + 1, 0, 0);
        cyc(1, 1, 3, 0, 0, 0, 0, 0, 1, 9);
        chk("sim_rd", 32'(phys_rd), 63);
        chk("sim_empty", 32'(free_list_empty), 0);
        cyc(1, 1, 4, 0, 0);
        chk("sim_next_rd", 32'(phys_rd), 9);
        chk("sim_empty_after", 32'(free_list_empty), 1);
        // reset with a packet in flight
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
        cyc(1, 1, 1, 2, 3, 5);
        dec_valid = 1;
        do_reset();
        chk("midreset_we", 32'(write_enable), 0);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 63), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 63));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage directly upstream of the issue queue.
- Accepts one decoded instruction per cycle and maps architectural rs1/rs2/rd to physical registers through a register alias table (RAT).
- Allocates a new destination from a circular free list and hands a registered packet to the issue queue's rename-side write port.
- Recycles physical registers released by the ROB at commit.

Parameters:
- ARCH_REGS, 32, architectural registers (x0..x31).
- PHYS_REGS, 64, physical registers.
- ARCH_W, 5, architectural index width.
- PHYS_W, 6, physical index width.
- FREE_DEPTH, PHYS_REGS-ARCH_REGS (32), free-list capacity.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  stage can accept this cycle
- dec_rd  in  5  architectural destination register
- dec_rs1  in  5  architectural source 1
- dec_rs2  in  5  architectural source 2
- dec_writes_rd  in  1  instruction writes rd
- dec_funct3  in  3  funct3 passthrough
- dec_funct7  in  7  funct7 passthrough
- dec_opcode  in  7  opcode passthrough
- dec_immediate  in  32  immediate passthrough
- rob_tail_index  in  6  ROB entry index assigned to this instruction
- rob_full  in  1  ROB cannot accept
- issue_queue_full  in  1  backpressure from issue queue
- commit_free_enable  in  1  ROB releases a physical register
- commit_free_phys  in  6  physical register being released
- write_enable  out  1  packet valid to issue queue (one-cycle pulse)
- phys_rd  out  6  allocated destination (0 when none)
- phys_rs1  out  6  mapped source 1
- phys_rs2  out  6  mapped source 2
- funct3  out  3  registered passthrough
- funct7  out  7  registered passthrough
- opcode  out  7  registered passthrough
- immediate  out  32  registered passthrough
- ROB_entry_index  out  6  registered rob_tail_index
- old_phys_rd  out  6  previous mapping of rd, sent to ROB for freeing at commit
- free_list_empty  out  1  free count == 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high; the reset port is named reset.
- Reset state:
  - RAT[i]=i for i=0..31.
  - Free-list slot k holds 32+k; head=0, tail=0, count=32.
  - All outputs 0, except dec_ready=1 and free_list_empty=0.
- Readiness: dec_ready = !issue_queue_full && !rob_full && (count != 0). It is conservative and independent of dec_* inputs.
- Accept: accept = dec_valid && dec_ready. All outputs are registered, so an accepted instruction appears on the outputs the next cycle with write_enable=1. write_enable=0 on every non-accept cycle. Other outputs hold their last value when write_enable=0.
- Source mapping:
  - phys_rs1 = RAT[dec_rs1] and phys_rs2 = RAT[dec_rs2], both read before this cycle's RAT update.
  - Example: add x5,x5,x5 reads the old mapping of x5.
  - Architectural register 0 always maps to physical 0, and RAT[0] is never written.
- Allocation, when accept && dec_writes_rd && dec_rd != 0:
  - phys_rd = free_list[head]; old_phys_rd = RAT[dec_rd].
  - RAT[dec_rd] <= free_list[head]; head <= head+1 (mod 32); count decrements.
  - Otherwise phys_rd=0, old_phys_rd=0, and there is no pop.
- Free, when commit_free_enable && commit_free_phys != 0:
  - free_list[tail] <= commit_free_phys; tail <= tail+1 (mod 32); count increments.
  - A pushed register becomes allocatable no earlier than the next cycle; no same-cycle bypass.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal even when count==1 (the pop takes the old head).
- Illegal push:
  - Push when count==32 is dropped, with no state change; the bench flags it.
  - Push of physical 0 is ignored.
- Pointer wrap: 5-bit head and tail wrap naturally. count is 6 bits, range 0..32.
- free_list_empty is combinational from count.
- reset asserted mid-operation: all state returns to the reset values on that edge, and any in-flight packet is dropped (write_enable=0).
- Out of scope: branch-misprediction RAT checkpoint/restore (handled by a later recovery block).

Decomposition:
- Shared package rename_pkg:
  - ARCH_W, PHYS_W, ARCH_REGS, PHYS_REGS, FREE_DEPTH.
  - A struct typedef for the rename-to-issue packet (rd, rs1, rs2, funct3, funct7, opcode, immediate, rob index).
- One sub-module: free_list. A circular FIFO with reset preload 32..63, push/pop ports, count and empty outputs. It is also reused later by recovery logic.
- The RAT stays inline as a 32x6 register array.

Test Plan:
- Reset, then add x1,x2,x3 with rob_tail_index=20 -> next cycle: write_enable=1, phys_rd=32, phys_rs1=2, phys_rs2=3, old_phys_rd=1, ROB_entry_index=20.
- Back-to-back x1=x2+x3 then x4=x1+x1 -> second packet: phys_rs1=phys_rs2=32, phys_rd=33, old_phys_rd=4.
- add x5,x5,x5 -> phys_rs1=phys_rs2=5, phys_rd=32, old_phys_rd=5. A following instruction reading x5 gets 32.
- rd=0 with dec_writes_rd=1 -> phys_rd=0, old_phys_rd=0, no pop: the next allocating instruction still receives 32.
- Free-list exhaustion:
  - 32 allocating instructions -> free_list_empty=1, dec_ready=0, write_enable stays 0 while dec_valid is held.
  - commit_free_phys=7 -> dec_ready=1 the next cycle, and the next allocation returns phys_rd=7.
- Backpressure and simultaneous events:
  - issue_queue_full=1 with dec_valid=1 -> write_enable=0 and the RAT is unchanged.
  - With count==1, a same-cycle commit free of 9 plus an allocation -> the allocation gets the old head, count stays 1, and the next allocation gets 9.
